// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared definitions for the bubble-sort controller: FSM states, counter width,
// default geometry and a saturating-increment helper.
package bubble_sort_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SWAP_CNT_W = 8;
  localparam int DEF_N      = 8;
  localparam int DEF_W      = 4;

  function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
    return (v == '1) ? v : v + SWAP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bubble_sort_ctrl_le_w.sv
// W-bit combinational comparator, o = (a <= b). Shared by every compare of the sort.
module le_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         o
);

  assign o = (a <= b);

endmodule

// File: rtl/bubble_sort_ctrl.sv
// In-place ascending bubble sort of an N-entry register buffer, one compare per clock.
// Optional feature macro SORT_EARLY_EXIT_EN: stop after the first pass with no swap.
module bubble_sort_ctrl
  import bubble_sort_ctrl_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int W  = DEF_W,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [W-1:0]          wr_data,
  input  logic                  start,
  input  logic [AW-1:0]         rd_addr,
  output logic [W-1:0]          rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_cnt
);

  state_t                  state_q, state_d;
  logic [W-1:0]            entry_q [N];
  logic [AW-1:0]           idx_q, pass_q;
  logic [AW-1:0]           idx_nxt, last_idx;
  logic [SWAP_CNT_W-1:0]   swap_cnt_q;
  logic [W-1:0]            cmp_a, cmp_b;
  logic                    in_order;
  logic                    do_swap;
  logic                    pass_end;
  logic                    last_pass;
  logic                    sort_end;
  logic                    sort_go;
  logic                    wr_hit;

  // ---------------------------------------------------------------------------
  // Compare datapath: a single comparator sees the adjacent pair at idx.
  // ---------------------------------------------------------------------------
  assign idx_nxt  = idx_q + AW'(1);
  assign last_idx = AW'(N - 2) - pass_q;
  assign cmp_a    = entry_q[idx_q];
  assign cmp_b    = entry_q[idx_nxt];

  le_w #(.W(W)) u_le (
    .a (cmp_a),
    .b (cmp_b),
    .o (in_order)
  );

  // Equal neighbours count as in order, which keeps the sort stable.
  assign do_swap   = (state_q == S_CMP) && !in_order;
  assign pass_end  = (idx_q == last_idx);
  assign last_pass = (pass_q == AW'(N - 2));
  assign sort_go   = (state_q == S_IDLE) && start;
  assign wr_hit    = (state_q == S_IDLE) && wr_en && (int'(wr_addr) < N);

`ifdef SORT_EARLY_EXIT_EN
  logic swapped_q;

  // A pass with no swap anywhere (including this final compare) means sorted.
  assign sort_end = pass_end && (last_pass || !(swapped_q || do_swap));

  always_ff @(posedge clk) begin
    if (rst) begin
      swapped_q <= 1'b0;
    end else if (sort_go) begin
      swapped_q <= 1'b0;
    end else if (state_q == S_CMP) begin
      swapped_q <= pass_end ? 1'b0 : (swapped_q | do_swap);
    end
  end
`else
  assign sort_end = pass_end && last_pass;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registered state is always assigned with <= so every flop samples
    // pre-edge values; blocking assignments here would create ordering races.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        if (sort_end) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pass / index / swap counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      pass_q     <= '0;
      swap_cnt_q <= '0;
    end else if (sort_go) begin
      idx_q      <= '0;
      pass_q     <= '0;
      swap_cnt_q <= '0;
    end else if (state_q == S_CMP) begin
      if (do_swap) swap_cnt_q <= sat_inc(swap_cnt_q);
      if (pass_end) begin
        idx_q  <= '0;
        pass_q <= pass_q + AW'(1);
      end else begin
        idx_q  <= idx_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry buffer: loaded in IDLE, rearranged in place during CMP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the buffer is a flop array that must read back as zero after reset,
    // so every entry is cleared here; this also keeps it out of RAM inference.
    if (rst) begin
      for (int i = 0; i < N; i++) entry_q[i] <= '0;
    end else if (wr_hit) begin
      entry_q[wr_addr] <= wr_data;
    end else if (do_swap) begin
      entry_q[idx_q]   <= cmp_b;
      entry_q[idx_nxt] <= cmp_a;
    end
  end

  assign rd_data  = (int'(rd_addr) < N) ? entry_q[rd_addr] : '0;
  assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl against a rank/inversion-count reference
// model; honours SORT_EARLY_EXIT_EN for the expected latency.
module tb_bubble_sort_ctrl;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int AW = 3;

  typedef logic [W-1:0] arr_t [N];

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [7:0]    swap_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bubble_sort_ctrl #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  // ---------------- reference model ----------------
  // Stable sort by rank: element i lands after every smaller value and after
  // equal values that came before it.
  function automatic arr_t model_sorted(input arr_t a);
    arr_t s;
    for (int i = 0; i < N; i++) begin
      int r = 0;
      for (int j = 0; j < N; j++)
        if (a[j] < a[i] || (a[j] == a[i] && j < i)) r++;
      s[r] = a[i];
    end
    return s;
  endfunction

  // Adjacent-swap sorting performs exactly one swap per strict inversion.
  function automatic int model_swaps(input arr_t a);
    int n = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (a[i] > a[j]) n++;
    return n;
  endfunction

  // Cycles from the start-capturing edge until done is visible: compares + 1.
  function automatic int model_latency(input arr_t a);
    int compares = N * (N - 1) / 2;
`ifdef SORT_EARLY_EXIT_EN
    int max_left = 0;
    int passes;
    for (int i = 0; i < N; i++) begin
      int left = 0;
      for (int j = 0; j < i; j++) if (a[j] > a[i]) left++;
      if (left > max_left) max_left = left;
    end
    passes   = (max_left + 1 < N - 1) ? max_left + 1 : N - 1;
    compares = 0;
    for (int p = 0; p < passes; p++) compares += N - 1 - p;
`endif
    return compares + 1;
  endfunction

  // ---------------- helpers ----------------
  task automatic check_readout(input string name, input arr_t exp);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      #1;
      checks++;
      if (rd_data !== exp[i]) begin
        errors++;
        $display("FAIL %s rd_data[%0d]: got %0d expected %0d", name, i, rd_data, exp[i]);
      end
    end
  endtask

  task automatic run_sort(input string name, input arr_t a,
                          input bit with_start_write, input bit inject);
    arr_t exp;
    int   lat, cyc, busy_cyc, extra_done;
    bit   seen;
    exp = model_sorted(a);
    lat = model_latency(a);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = a[i];
      start   = with_start_write && (i == N - 1);
    end
    if (!with_start_write) begin
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    cyc = 1; busy_cyc = 0; seen = 1'b0;
    while (cyc < 200) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) busy_cyc++;
      if (inject && cyc == 5) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 4'd15; start = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      cyc++;
    end
    checks++;
    if (!seen || cyc != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, cyc, seen, lat);
    end
    checks++;
    if (busy_cyc != lat - 1) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc, lat - 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
    end
    checks++;
    if (swap_cnt !== 8'(model_swaps(a))) begin
      errors++;
      $display("FAIL %s swap_cnt: got %0d expected %0d", name, swap_cnt, model_swaps(a));
    end
    extra_done = 0;
    for (int k = 0; k < (inject ? 40 : 3); k++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL %s extra_activity: got %0d cycles expected 0", name, extra_done);
    end
    checks++;
    if (swap_cnt !== 8'(model_swaps(a))) begin
      errors++;
      $display("FAIL %s swap_cnt_hold: got %0d expected %0d", name, swap_cnt, model_swaps(a));
    end
    check_readout(name, exp);
  endtask

  function automatic arr_t random_arr();
    arr_t r;
    for (int i = 0; i < N; i++) r[i] = W'($urandom_range(0, (1 << W) - 1));
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arr_t zero;
    for (int i = 0; i < N; i++) zero[i] = '0;
    rst = 1'b1; wr_en = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || swap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b swap_cnt=%0d expected 0/0/0",
               busy, done, swap_cnt);
    end
    check_readout("reset_buffer", zero);
  endtask

  task automatic test_fixed_vectors();
    arr_t v;
    v = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd0, 4'd2, 4'd4};
    run_sort("mixed", v, 1'b0, 1'b0);
    v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    run_sort("sorted", v, 1'b0, 1'b0);
    v = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    run_sort("reversed", v, 1'b0, 1'b0);
    v = '{4'd5, 4'd5, 4'd2, 4'd2, 4'd9, 4'd9, 4'd1, 4'd1};
    run_sort("dup_pairs", v, 1'b0, 1'b0);
    v = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    run_sort("all_equal", v, 1'b0, 1'b0);
  endtask

  task automatic test_write_with_start();
    arr_t v;
    v = '{4'd9, 4'd8, 4'd12, 4'd1, 4'd3, 4'd14, 4'd2, 4'd0};
    run_sort("write_with_start", v, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_while_busy();
    arr_t v;
    v = '{4'd4, 4'd2, 4'd7, 4'd1, 4'd3, 4'd5, 4'd6, 4'd0};
    run_sort("ignore_while_busy", v, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) run_sort($sformatf("random%0d", t), random_arr(), t[0], 1'b0);
  endtask

  task automatic test_reset_mid_sort();
    arr_t v, zero;
    int   activity;
    for (int i = 0; i < N; i++) zero[i] = '0;
    v = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = v[i];
    end
    @(negedge clk);
    wr_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || swap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b swap_cnt=%0d expected 0/0/0",
               busy, done, swap_cnt);
    end
    rst = 1'b0;
    check_readout("mid_reset_buffer", zero);
    activity = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) activity++;
    end
    checks++;
    if (activity != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", activity);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_write_with_start();
    test_ignore_while_busy();
    test_random();
    test_reset_mid_sort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
